// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2R/1W register file with hardwired-zero r0, link-register
// write select, sequential clear engine and per-register pending scoreboard.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through forwarding on reads.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr_req,
    input  logic [ADDR_W-1:0] i_rd_addr_1,
    input  logic [ADDR_W-1:0] i_rd_addr_2,
    output logic [DATA_W-1:0] o_rd_data_1,
    output logic [DATA_W-1:0] o_rd_data_2,
    output logic              o_rd_pend_1,
    output logic              o_rd_pend_2,
    input  logic              i_wr_en,
    input  logic              i_wr_link,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_iss_en,
    input  logic [ADDR_W-1:0] i_iss_addr,
    output logic              o_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic              w_idle;
    logic [ADDR_W-1:0] w_wr_tgt;
    logic              w_wr_ok;
    logic              w_iss_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    assign w_idle   = (r_state == S_IDLE);
    assign o_busy   = !w_idle;
    assign w_wr_tgt = i_wr_link ? LINK_A : i_wr_addr;
    // A clear request takes the whole edge; writes/issues in that cycle are dropped.
    assign w_wr_ok  = w_idle && !i_clr_req && i_wr_en  && (w_wr_tgt   != '0);
    assign w_iss_ok = w_idle && !i_clr_req && i_iss_en && (i_iss_addr != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_mem_we      = 1'b0;
        w_mem_addr    = w_wr_tgt;
        w_mem_data    = i_wr_data;
        case (r_state)
            S_CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_cnt;
                w_mem_data    = '0;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (&r_clr_cnt) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_mem_we = w_wr_ok;
                if (i_clr_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) r_mem[w_mem_addr] <= w_mem_data;
    end

    // Issue is applied after the write clear so a same-address issue stays pending.
    always_ff @(posedge i_clk) begin
        if (i_rst || (w_idle && i_clr_req)) begin
            r_pend <= '0;
        end else begin
            if (w_wr_ok)  r_pend[w_wr_tgt]   <= 1'b0;
            if (w_iss_ok) r_pend[i_iss_addr] <= 1'b1;
        end
    end

    always_comb begin
        o_rd_data_1 = '0;
        o_rd_pend_1 = 1'b0;
        if (w_idle && (i_rd_addr_1 != '0)) begin
            o_rd_data_1 = r_mem[i_rd_addr_1];
            o_rd_pend_1 = r_pend[i_rd_addr_1];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (w_wr_tgt == i_rd_addr_1)) begin
                o_rd_data_1 = i_wr_data;
                o_rd_pend_1 = 1'b0;
            end
`else
`endif
        end
    end

    always_comb begin
        o_rd_data_2 = '0;
        o_rd_pend_2 = 1'b0;
        if (w_idle && (i_rd_addr_2 != '0)) begin
            o_rd_data_2 = r_mem[i_rd_addr_2];
            o_rd_pend_2 = r_pend[i_rd_addr_2];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (w_wr_tgt == i_rd_addr_2)) begin
                o_rd_data_2 = i_wr_data;
                o_rd_pend_2 = 1'b0;
            end
`else
`endif
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_reg_file_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int LINK   = 31;

    logic              clk = 1'b0;
    logic              rst, clr_req, wr_en, wr_link, iss_en;
    logic [ADDR_W-1:0] rd_addr_1, rd_addr_2, wr_addr, iss_addr;
    logic [DATA_W-1:0] wr_data, rd_data_1, rd_data_2;
    logic              rd_pend_1, rd_pend_2, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] m_mem  [DEPTH];
    logic              m_pend [DEPTH];
    int                m_busy;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr_req(clr_req),
        .i_rd_addr_1(rd_addr_1), .i_rd_addr_2(rd_addr_2),
        .o_rd_data_1(rd_data_1), .o_rd_data_2(rd_data_2),
        .o_rd_pend_1(rd_pend_1), .o_rd_pend_2(rd_pend_2),
        .i_wr_en(wr_en), .i_wr_link(wr_link), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy(busy)
    );

    function automatic int tgt();
        return wr_link ? LINK : int'(wr_addr);
    endfunction

    function automatic logic fwd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return wr_en && !clr_req && (tgt() == int'(a));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (m_busy > 0 || a == 0) return '0;
        if (fwd(a)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        if (m_busy > 0 || a == 0) return 1'b0;
        if (fwd(a)) return 1'b0;
        return m_pend[a];
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            m_busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (clr_req) begin
            m_busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
        end else begin
            if (wr_en && tgt() != 0) begin m_mem[tgt()] = wr_data; m_pend[tgt()] = 1'b0; end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr_req = 0; wr_en = 0; wr_link = 0; iss_en = 0;
        wr_addr = '0; wr_data = '0; iss_addr = '0;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1; tick(); rst = 0;
        n_tests++;
        if (busy !== 1'b1 || rd_data_1 !== '0 || rd_pend_1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: busy=%b data=%h pend=%b, want busy=1 data=0 pend=0", busy, rd_data_1, rd_pend_1);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            rd_addr_1 = ADDR_W'($urandom_range(0, DEPTH-1));
            #1;
            n_tests++;
            if (rd_data_1 !== '0) begin
                n_fail++; $display("FAIL reset_read_zero: got %h want 0", rd_data_1);
            end
            tick(); cyc++;
        end
        n_tests++;
        if (cyc !== DEPTH) begin
            n_fail++; $display("FAIL reset_busy_len: got %0d cycles want %0d", cyc, DEPTH);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr_1 = 5; #1;
        n_tests++;
        if (rd_data_1 !== exp_data(5)) begin
            n_fail++; $display("FAIL wr_same_cycle: got %h want %h", rd_data_1, exp_data(5));
        end
        tick(); wr_en = 0; #1;
        n_tests++;
        if (rd_data_1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_r5: got %h want deadbeef", rd_data_1);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr_2 = 0;
        tick(); wr_en = 0; #1;
        n_tests++;
        if (rd_data_2 !== '0) begin
            n_fail++; $display("FAIL wr_r0: got %h want 0", rd_data_2);
        end
    endtask

    task automatic test_link();
        wr_en = 1; wr_addr = 7; wr_data = 32'h77; tick();
        wr_link = 1; wr_addr = 7; wr_data = 32'h400; tick();
        wr_en = 0; wr_link = 0; rd_addr_1 = 31; rd_addr_2 = 7; #1;
        n_tests++;
        if (rd_data_1 !== 32'h400 || rd_data_2 !== 32'h77) begin
            n_fail++; $display("FAIL link_write: r31=%h r7=%h want r31=400 r7=77", rd_data_1, rd_data_2);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr_1 = 9;
        iss_en = 1; iss_addr = 9; tick(); iss_en = 0; #1;
        n_tests++;
        if (rd_pend_1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_issue: got %b want 1", rd_pend_1);
        end
        wr_en = 1; wr_addr = 9; wr_data = 32'h99; tick(); wr_en = 0; #1;
        n_tests++;
        if (rd_pend_1 !== 1'b0) begin
            n_fail++; $display("FAIL sb_write_clear: got %b want 0", rd_pend_1);
        end
        wr_en = 1; iss_en = 1; iss_addr = 9; tick(); wr_en = 0; iss_en = 0; #1;
        n_tests++;
        if (rd_pend_1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_set_wins: got %b want 1", rd_pend_1);
        end
        iss_en = 1; iss_addr = 0; rd_addr_2 = 0; tick(); iss_en = 0; #1;
        n_tests++;
        if (rd_pend_2 !== 1'b0) begin
            n_fail++; $display("FAIL sb_r0: got %b want 0", rd_pend_2);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        wr_en = 1; wr_addr = 5; wr_data = 32'h5555; tick(); wr_en = 0;
        clr_req = 1; tick(); clr_req = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1; tick(); rst = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            wr_en = 1; wr_addr = 5; wr_data = $urandom;
            iss_en = 1; iss_addr = 6;
            tick(); cyc++;
        end
        wr_en = 0; iss_en = 0; rd_addr_1 = 5; rd_addr_2 = 6; #1;
        n_tests++;
        if (cyc !== DEPTH) begin
            n_fail++; $display("FAIL midclr_busy_len: got %0d cycles want %0d", cyc, DEPTH);
        end
        n_tests++;
        if (rd_data_1 !== '0 || rd_pend_2 !== 1'b0) begin
            n_fail++; $display("FAIL midclr_ignored: r5=%h pend6=%b want 0/0", rd_data_1, rd_pend_2);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 3; wr_data = 32'h1111; tick();
        wr_data = 32'hA5A5; rd_addr_1 = 3; #1;
        n_tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data_1 !== 32'hA5A5) begin
            n_fail++; $display("FAIL bypass_fwd: got %h want a5a5", rd_data_1);
        end
`else
        if (rd_data_1 !== 32'h1111) begin
            n_fail++; $display("FAIL bypass_off: got %h want 1111", rd_data_1);
        end
`endif
        tick(); wr_en = 0; #1;
        n_tests++;
        if (rd_data_1 !== 32'hA5A5) begin
            n_fail++; $display("FAIL bypass_after: got %h want a5a5", rd_data_1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clr_req   = ($urandom_range(0, 99) < 2);
            wr_en     = $urandom_range(0, 1);
            wr_link   = ($urandom_range(0, 9) == 0);
            wr_addr   = ADDR_W'($urandom_range(0, DEPTH-1));
            wr_data   = $urandom;
            iss_en    = ($urandom_range(0, 9) < 4);
            iss_addr  = ADDR_W'($urandom_range(0, DEPTH-1));
            rd_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH-1));
            rd_addr_2 = ($urandom_range(0, 3) == 0) ? iss_addr : ADDR_W'($urandom_range(0, DEPTH-1));
            #1;
            n_tests++;
            if (busy !== (m_busy > 0) || rd_data_1 !== exp_data(rd_addr_1) || rd_data_2 !== exp_data(rd_addr_2)
                || rd_pend_1 !== exp_pend(rd_addr_1) || rd_pend_2 !== exp_pend(rd_addr_2)) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: busy=%b d1=%h d2=%h p1=%b p2=%b want busy=%b d1=%h d2=%h p1=%b p2=%b",
                         c, busy, rd_data_1, rd_data_2, rd_pend_1, rd_pend_2, (m_busy > 0),
                         exp_data(rd_addr_1), exp_data(rd_addr_2), exp_pend(rd_addr_1), exp_pend(rd_addr_2));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs(); rst = 1; rd_addr_1 = '0; rd_addr_2 = '0; m_busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_link();
        test_scoreboard();
        test_reset_mid_clear();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
